// File: rtl/push_btn_bank.sv
// rtl/push_btn_bank.sv - four sticky push-button flags read through a 12-bit instruction word
module push_btn_bank (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] inst,
  input  logic        inst_en,
  input  logic        btn0,
  input  logic        btn1,
  input  logic        btn2,
  input  logic        btn3,
  output logic [3:0]  btn_state
);

  localparam logic [0:0] READY = 1'b0;
  localparam logic [0:0] ERROR = 1'b1;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_RSA = 4'h1;
  localparam logic [3:0] OP_RS0 = 4'h2;
  localparam logic [3:0] OP_RS1 = 4'h3;
  localparam logic [3:0] OP_RS2 = 4'h4;
  localparam logic [3:0] OP_RS3 = 4'h5;

  logic [0:0] state;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] prev;
  logic [3:0] flag;
  logic [3:0] press;
  logic [3:0] hit;
  logic [3:0] sel;
  logic [3:0] opcode;

  assign opcode = inst[11:8];
  assign press  = sync2 & ~prev;
  // A press landing in the same cycle as a read is reported by that read.
  assign hit    = flag | press;

  always_comb begin
    sel = 4'b0000;
    case (opcode)
      OP_RSA:  sel = 4'b1111;
      OP_RS0:  sel = 4'b0001;
      OP_RS1:  sel = 4'b0010;
      OP_RS2:  sel = 4'b0100;
      OP_RS3:  sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= READY;
      sync1     <= 4'b0000;
      sync2     <= 4'b0000;
      prev      <= 4'b0000;
      flag      <= 4'b0000;
      btn_state <= 4'b0000;
    end else begin
      sync1 <= {btn3, btn2, btn1, btn0};
      sync2 <= sync1;
      prev  <= sync2;
      flag  <= hit;
      if (state == ERROR) begin
        btn_state <= 4'b0000;
      end else if (inst_en) begin
        if (opcode == OP_NOP) begin
          btn_state <= btn_state;
        end else if (opcode <= OP_RS3) begin
          btn_state <= hit & sel;
          flag      <= hit & ~sel;
        end else begin
          state     <= ERROR;
          btn_state <= 4'b0000;
        end
      end
    end
  end

endmodule

// File: tb/tb_push_btn_bank.sv
// tb/tb_push_btn_bank.sv - scoreboard bench for push_btn_bank
module tb_push_btn_bank;

  logic        clock;
  logic        reset;
  logic [11:0] inst;
  logic        inst_en;
  logic [3:0]  btn;
  logic [3:0]  btn_state;

  int passed;
  int total;
  logic [3:0] exp_q[$];

  push_btn_bank dut (
    .clock     (clock),
    .reset     (reset),
    .inst      (inst),
    .inst_en   (inst_en),
    .btn0      (btn[0]),
    .btn1      (btn[1]),
    .btn2      (btn[2]),
    .btn3      (btn[3]),
    .btn_state (btn_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Drive one instruction at the falling edge, predict, then compare after the next rising edge.
  task automatic issue(input string tag, input logic [3:0] op, input logic en, input logic [3:0] exp);
    logic [3:0] e;
    @(negedge clock);
    inst    = {op, 8'($urandom)};
    inst_en = en;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check(tag, btn_state, e);
    inst_en = 1'b0;
  endtask

  task automatic press(input int b);
    @(negedge clock);
    btn[b] = 1'b1;
    repeat (2) @(negedge clock);
    btn[b] = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check(tag, btn_state, 4'b0000);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    reset   = 1'b0;
    inst    = 12'h000;
    inst_en = 1'b0;
    btn     = 4'b0000;

    do_reset("reset");

    issue("idle_nop", 4'h0, 1'b1, 4'b0000);
    issue("idle_rsa", 4'h1, 1'b1, 4'b0000);
    issue("idle_rs0", 4'h2, 1'b1, 4'b0000);
    issue("idle_rs1", 4'h3, 1'b1, 4'b0000);
    issue("idle_rs2", 4'h4, 1'b1, 4'b0000);
    issue("idle_rs3", 4'h5, 1'b1, 4'b0000);

    press(1);
    issue("btn1_rsa", 4'h1, 1'b1, 4'b0010);
    issue("btn1_rsa_again", 4'h1, 1'b1, 4'b0000);

    press(0);
    press(0);
    issue("dbl_btn0_rsa", 4'h1, 1'b1, 4'b0001);
    issue("dbl_btn0_rsa_again", 4'h1, 1'b1, 4'b0000);

    press(0); press(1); press(2); press(3);
    issue("all_rs0", 4'h2, 1'b1, 4'b0001);
    issue("all_rs1", 4'h3, 1'b1, 4'b0010);
    issue("all_nop_hold", 4'h0, 1'b1, 4'b0010);
    issue("all_rs2", 4'h4, 1'b1, 4'b0100);
    issue("all_rs3", 4'h5, 1'b1, 4'b1000);
    issue("all_rsa_empty", 4'h1, 1'b1, 4'b0000);

    press(2);
    issue("keep_rs0_other", 4'h2, 1'b1, 4'b0000);
    issue("keep_rs2", 4'h4, 1'b1, 4'b0100);

    press(3);
    issue("hold_rs3", 4'h5, 1'b1, 4'b1000);
    issue("invalid_0xb", 4'hB, 1'b1, 4'b0000);
    press(0);
    issue("error_rs0", 4'h2, 1'b1, 4'b0000);
    issue("error_rsa", 4'h1, 1'b1, 4'b0000);
    issue("error_nop", 4'h0, 1'b1, 4'b0000);
    do_reset("reset_from_error");
    issue("post_reset_rsa", 4'h1, 1'b1, 4'b0000);
    press(3);
    issue("post_reset_btn3", 4'h1, 1'b1, 4'b1000);

    press(0);
    issue("en_rs0", 4'h2, 1'b1, 4'b0001);
    press(1);
    issue("en_off_rs1", 4'h3, 1'b0, 4'b0001);
    issue("en_off_rs1_again", 4'h3, 1'b0, 4'b0001);
    issue("en_on_rs1", 4'h3, 1'b1, 4'b0010);

    // btn2 rises so that its one-cycle press pulse coincides with the RSA edge.
    @(negedge clock);
    btn[2] = 1'b1;
    @(negedge clock);
    issue("coincide_rsa", 4'h1, 1'b1, 4'b0100);
    issue("coincide_rsa_again", 4'h1, 1'b1, 4'b0000);
    @(negedge clock);
    btn[2] = 1'b0;
    repeat (4) @(negedge clock);
    issue("release_no_press", 4'h1, 1'b1, 4'b0000);

    press(1);
    issue("invalid_0x6", 4'h6, 1'b1, 4'b0000);
    do_reset("reset_clears_flags");
    issue("flags_cleared", 4'h1, 1'b1, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
